// File: rtl/fu_cmpl_buf.sv
// Per-FU completion buffer: show-ahead FIFO that holds FU results until the CDB
// arbiter grants the head entry, so results that lose arbitration are not dropped.
module fu_cmpl_buf #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TAG_W  = 7,
  parameter int unsigned PRD_W  = 7,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              fu_valid_i,
  output logic              fu_ready_o,
  input  logic [TAG_W-1:0]  fu_rob_tag_i,
  input  logic [PRD_W-1:0]  fu_prd_i,
  input  logic [DATA_W-1:0] fu_data_i,
  input  logic              fu_rd_used_i,
  output logic              out_valid_o,
  output logic [TAG_W-1:0]  out_rob_tag_o,
  output logic [PRD_W-1:0]  out_prd_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_rd_used_o,
  input  logic              out_grant_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              overflow_o
);

  localparam int unsigned EntW = TAG_W + PRD_W + DATA_W + 1;

  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             push, pop;
  logic [EntW-1:0]  head;

  // Ready is a function of registered occupancy only; no path from out_grant_i.
  assign fu_ready_o  = (count_q != CNT_W'(DEPTH));
  assign out_valid_o = (count_q != '0);
  assign push        = fu_valid_i && fu_ready_o;
  assign pop         = out_valid_o && out_grant_i;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | (fu_valid_i & ~fu_ready_o);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; a flushed push is simply never written.
  always_ff @(posedge clk) begin
    if (push && !flush_i) begin
      mem_q[wr_ptr_q] <= {fu_rob_tag_i, fu_prd_i, fu_data_i, fu_rd_used_i};
    end
  end

  assign head = out_valid_o ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    {out_rob_tag_o, out_prd_o, out_data_o, out_rd_used_o} = head;
  end

  assign count_o    = count_q;
  assign overflow_o = overflow_q;

endmodule

// File: tb/tb_fu_cmpl_buf.sv
// Scoreboard bench for fu_cmpl_buf: stimulus queues expected results, a negedge
// monitor pops and compares them whenever the head is granted.
module tb_fu_cmpl_buf;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TAG_W  = 7;
  localparam int unsigned PRD_W  = 7;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [PRD_W-1:0]  prd;
    logic [DATA_W-1:0] data;
    logic              rd;
  } ent_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush_i;
  logic              fu_valid_i;
  logic              fu_ready_o;
  logic [TAG_W-1:0]  fu_rob_tag_i;
  logic [PRD_W-1:0]  fu_prd_i;
  logic [DATA_W-1:0] fu_data_i;
  logic              fu_rd_used_i;
  logic              out_valid_o;
  logic [TAG_W-1:0]  out_rob_tag_o;
  logic [PRD_W-1:0]  out_prd_o;
  logic [DATA_W-1:0] out_data_o;
  logic              out_rd_used_o;
  logic              out_grant_i;
  logic [CNT_W-1:0]  count_o;
  logic              overflow_o;

  fu_cmpl_buf #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W),
    .PRD_W (PRD_W),
    .DATA_W(DATA_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .fu_valid_i   (fu_valid_i),
    .fu_ready_o   (fu_ready_o),
    .fu_rob_tag_i (fu_rob_tag_i),
    .fu_prd_i     (fu_prd_i),
    .fu_data_i    (fu_data_i),
    .fu_rd_used_i (fu_rd_used_i),
    .out_valid_o  (out_valid_o),
    .out_rob_tag_o(out_rob_tag_o),
    .out_prd_o    (out_prd_o),
    .out_data_o   (out_data_o),
    .out_rd_used_o(out_rd_used_o),
    .out_grant_i  (out_grant_i),
    .count_o      (count_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  ent_t sb[$];
  int   mcnt = 0;
  bit   movf = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Granted head must match the oldest queued result.
  always @(negedge clk) begin
    if (rst_n && out_valid_o && out_grant_i) begin
      if (sb.size() == 0) begin
        chk("grant_on_empty_model", 64'(out_rob_tag_o), 64'hFFFF);
      end else begin
        ent_t e;
        e = sb.pop_front();
        chk("pop_tag", 64'(out_rob_tag_o), 64'(e.tag));
        chk("pop_prd", 64'(out_prd_o), 64'(e.prd));
        chk("pop_data", 64'(out_data_o), 64'(e.data));
        chk("pop_rd_used", 64'(out_rd_used_o), 64'(e.rd));
      end
    end
  end

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(count_o), 64'(mcnt));
    chk({tag, "_ready"}, 64'(fu_ready_o), 64'(mcnt != DEPTH));
    chk({tag, "_valid"}, 64'(out_valid_o), 64'(mcnt != 0));
    chk({tag, "_overflow"}, 64'(overflow_o), 64'(movf));
    if (mcnt == 0) begin
      chk({tag, "_empty_data"}, 64'(out_data_o), 64'h0);
      chk({tag, "_empty_tag"}, 64'(out_rob_tag_o), 64'h0);
    end else if (sb.size() != 0) begin
      chk({tag, "_head_tag"}, 64'(out_rob_tag_o), 64'(sb[0].tag));
      chk({tag, "_head_data"}, 64'(out_data_o), 64'(sb[0].data));
    end
  endtask

  // One clock cycle: drive at posedge+1, update model after the next edge, check.
  task automatic step(input string name, input bit v, input int tag, input int prd,
                      input logic [31:0] data, input bit rd, input bit g, input bit fl);
    bit   acc, pop;
    ent_t e;
    fu_valid_i   = v;
    fu_rob_tag_i = TAG_W'(tag);
    fu_prd_i     = PRD_W'(prd);
    fu_data_i    = data;
    fu_rd_used_i = rd;
    out_grant_i  = g;
    flush_i      = fl;
    acc = v && (mcnt != DEPTH);
    pop = g && (mcnt != 0);
    if (v && mcnt == DEPTH) movf = 1'b1;
    e = '{tag: TAG_W'(tag), prd: PRD_W'(prd), data: data, rd: rd};
    @(posedge clk);
    #1;
    if (fl) begin
      sb.delete();
      mcnt = 0;
    end else begin
      if (acc) sb.push_back(e);
      mcnt = mcnt + int'(acc) - int'(pop);
    end
    check_state(name);
  endtask

  task automatic idle(input string name, input bit g);
    step(name, 1'b0, 0, 0, 32'h0, 1'b0, g, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    {flush_i, fu_valid_i, out_grant_i, fu_rd_used_i} = '0;
    fu_rob_tag_i = '0;
    fu_prd_i     = '0;
    fu_data_i    = '0;
    #3;
    check_state("reset");
    #14;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("idle", 1'b0);

    // Single result held for two cycles, then granted.
    step("push5", 1'b1, 5, 12, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0);
    idle("hold1", 1'b0);
    idle("hold2", 1'b0);
    idle("grant5", 1'b1);
    idle("after5", 1'b0);

    // Fill, overflow, full+grant+valid, then drain.
    for (int i = 1; i <= 4; i++) begin
      step("fill", 1'b1, i, 40 + i, 32'h1000 + 32'(i), i[0], 1'b0, 1'b0);
    end
    step("overflow", 1'b1, 9, 9, 32'h9999, 1'b1, 1'b0, 1'b0);
    step("full_grant_push", 1'b1, 10, 10, 32'hAAAA, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) idle("drain", 1'b1);
    idle("drained", 1'b1);

    // Wrap-around streaming with a grant every cycle.
    for (int i = 0; i < 10; i++) begin
      step("stream", 1'b1, i, 100 + i, 32'hC0DE_0000 + 32'(i * 7), ~i[0], 1'b1, 1'b0);
    end
    idle("stream_last", 1'b1);
    idle("stream_done", 1'b0);

    // Flush overriding a concurrent push and grant.
    for (int i = 20; i < 23; i++) begin
      step("preflush", 1'b1, i, i, 32'h2000 + 32'(i), 1'b1, 1'b0, 1'b0);
    end
    step("flush", 1'b1, 23, 23, 32'h2023, 1'b1, 1'b1, 1'b1);
    idle("postflush1", 1'b1);
    idle("postflush2", 1'b0);

    // Asynchronous reset while holding entries.
    step("prereset_a", 1'b1, 30, 3, 32'h3030, 1'b1, 1'b0, 1'b0);
    step("prereset_b", 1'b1, 31, 4, 32'h3131, 1'b0, 1'b0, 1'b0);
    fu_valid_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    mcnt = 0;
    movf = 1'b0;
    check_state("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle("after_reset", 1'b1);
    step("post_reset_push", 1'b1, 77, 55, 32'h0BAD_F00D, 1'b0, 1'b0, 1'b0);
    idle("post_reset_grant", 1'b1);
    idle("final", 1'b0);

    chk("scoreboard_empty", 64'(sb.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
